// File: rtl/exception_sequencer.sv
// Multicycle exception/return sequencer: saves EPC, fetches the handler byte
// from the vector table after MEM_LATENCY wait cycles, loads PC, pulses done.
module exception_sequencer #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned NUM_CAUSES  = 3,
  parameter int unsigned VEC_BASE    = 253,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CAUSES-1:0] exc_req,
  input  logic                  rte_req,
  input  logic [ADDR_W-1:0]     pc_current,
  input  logic [ADDR_W-1:0]     epc_in,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic [1:0]            cause,
  output logic                  epc_write,
  output logic [ADDR_W-1:0]     epc_value,
  output logic                  mem_read,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  pc_write,
  output logic [ADDR_W-1:0]     pc_value,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE, SAVE_EPC, MEM_ADDR, MEM_WAIT, LOAD_PC, RTE, DONE
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t     state;
  logic [3:0] cnt;
  logic       req_any;
  logic [1:0] req_idx;

  // Lowest set request index wins.
  always_comb begin
    req_any = |exc_req;
    req_idx = '0;
    for (int unsigned i = NUM_CAUSES; i > 0; i--) begin
      if (exc_req[i-1]) req_idx = 2'(i - 1);
    end
  end

  // Outputs are registered alongside the state they belong to, so each one is
  // valid exactly during its state; read data is captured on the edge that
  // leaves the last wait cycle, when it is guaranteed valid.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cause     <= '0;
      busy      <= 1'b0;
      epc_write <= 1'b0;
      epc_value <= '0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      pc_write  <= 1'b0;
      pc_value  <= '0;
      done      <= 1'b0;
    end else begin
      epc_write <= 1'b0;
      epc_value <= '0;
      mem_read  <= 1'b0;
      pc_write  <= 1'b0;
      pc_value  <= '0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            state     <= SAVE_EPC;
            cause     <= req_idx;
            busy      <= 1'b1;
            epc_write <= 1'b1;
            epc_value <= pc_current - ADDR_W'(4);
          end else if (rte_req) begin
            state    <= RTE;
            busy     <= 1'b1;
            pc_write <= 1'b1;
            pc_value <= epc_in;
          end
        end
        SAVE_EPC: begin
          state    <= MEM_ADDR;
          mem_read <= 1'b1;
          mem_addr <= ADDR_W'(VEC_BASE) + ADDR_W'(cause);
        end
        MEM_ADDR: begin
          cnt <= LAT;
          if (LAT != 4'd0) begin
            state    <= MEM_WAIT;
            mem_read <= 1'b1;
          end else begin
            state    <= LOAD_PC;
            pc_write <= 1'b1;
            pc_value <= ADDR_W'(mem_rdata);
          end
        end
        MEM_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= LOAD_PC;
            pc_write <= 1'b1;
            pc_value <= ADDR_W'(mem_rdata);
          end else begin
            mem_read <= 1'b1;
          end
        end
        LOAD_PC: begin
          state    <= DONE;
          mem_addr <= '0;
          done     <= 1'b1;
        end
        RTE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Parametrised multicycle exception/return sequencer for the multicycle CPU, operating alongside the main control FSM.
- On an exception request it does four things in order: saves EPC, reads the handler byte from the vector table in memory after a configurable wait, loads PC, then signals completion.
- Generalises the fixed overflow, invalid-opcode and divide-by-zero state chains (each with two hard-coded wait states) into one engine with parametrised cause count, vector base and memory latency.
- Also performs RTE (PC <= EPC).

Parameters:
- ADDR_W, 32, width of PC/EPC/memory address.
- NUM_CAUSES, 3, number of exception request lines; index 0 is highest priority.
- VEC_BASE, 253, byte address of the vector for cause 0; cause i uses VEC_BASE+i.
- MEM_LATENCY, 2, wait cycles between address issue and valid read data; legal range 0..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- exc_req  in  NUM_CAUSES  exception request levels (bit0 overflow, bit1 invalid opcode, bit2 divide-by-zero).
- rte_req  in  1  return-from-exception request.
- pc_current  in  ADDR_W  current PC (already incremented by fetch).
- epc_in  in  ADDR_W  current EPC register contents.
- mem_rdata  in  8  byte read from memory.
- busy  out  1  high in every state except IDLE.
- cause  out  2  encoded index of the accepted cause, held until the next acceptance.
- epc_write  out  1  EPC register write enable.
- epc_value  out  ADDR_W  data for EPC.
- mem_read  out  1  memory read request.
- mem_addr  out  ADDR_W  memory byte address.
- pc_write  out  1  PC write enable.
- pc_value  out  ADDR_W  data for PC.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, wait counter=0, cause=0. All outputs 0, including busy, epc_write, mem_read, pc_write, done, mem_addr, epc_value and pc_value.
- Reset has priority over everything and aborts any sequence in progress on the next edge. No partial PC/EPC write occurs after an abort.
- States: IDLE, SAVE_EPC, MEM_ADDR, MEM_WAIT, LOAD_PC, RTE, DONE. Outputs are Moore-decoded from the state and the registered cause.
- IDLE:
  - If any exc_req bit is set, latch the lowest set index into cause and go to SAVE_EPC.
  - Else if rte_req is set, go to RTE.
  - Else stay in IDLE.
  - Exception wins over a simultaneous rte_req; that rte_req is dropped.
- SAVE_EPC: epc_write=1, epc_value=pc_current-4 (wraps modulo 2^ADDR_W). Next state MEM_ADDR.
- MEM_ADDR: mem_read=1, mem_addr=VEC_BASE+cause. Load the counter with MEM_LATENCY. Next state MEM_WAIT if MEM_LATENCY>0, else LOAD_PC.
- MEM_WAIT: mem_read and mem_addr held stable. Decrement the counter; leave for LOAD_PC when the counter reaches 1.
- LOAD_PC: pc_write=1, pc_value={zeros, mem_rdata} (zero-extended), mem_addr still held, mem_read=0. Next state DONE.
- RTE: pc_write=1, pc_value=epc_in. Next state DONE.
- DONE: done=1. Next state IDLE.
- Latency for an exception detected in cycle t:
  - epc_write in t+1.
  - pc_write in t+3+MEM_LATENCY.
  - done in t+4+MEM_LATENCY.
- Latency for an RTE detected in cycle t: pc_write in t+1, done in t+2.
- exc_req and rte_req are ignored while busy. A request still asserted when the sequencer returns to IDLE is accepted again, so requesters must deassert on done.
- A change in pc_current after SAVE_EPC has no effect on the sequence.

Test Plan:
- Overflow entry: MEM_LATENCY=2, pc_current=0x00000010, exc_req=3'b001 at t, mem[253]=0x40 -> epc_write=1 with epc_value=0x0000000C at t+1; mem_addr=253 at t+2..t+4; pc_write=1 with pc_value=0x00000040 at t+5; done at t+6; cause=0.
- Priority: exc_req=3'b110 with mem[254]=0x22 -> cause=1, mem_addr=254, pc_value=0x00000022. Raising bit0 while busy leaves the sequence unchanged.
- RTE and collision:
  - rte_req alone with epc_in=0x00001234 -> pc_write=1, pc_value=0x00001234 next cycle, done the cycle after.
  - rte_req together with exc_req=3'b100 -> exception path (mem_addr=255); no RTE pc_write.
- Latency sweep: MEM_LATENCY=0 -> pc_write exactly 3 cycles after the request. MEM_LATENCY=5 -> 8 cycles. mem_addr is stable throughout the wait.
- Reset mid-operation: drive reset=0 during MEM_WAIT -> next edge gives state IDLE with all outputs 0 and no pc_write. After release, a fresh request runs a complete sequence.
- Wrap and extension: pc_current=0x00000000 -> epc_value=0xFFFFFFFC. mem_rdata=0xFF -> pc_value=0x000000FF (no sign extension).
